sram_fb_arbiter: RTL

// Parametrised framebuffer SRAM arbiter for the paint datapath, sitting between VGA scan-out, draw logic and off-chip SRAM.

---
 rtl/sram_fb_arbiter_if.sv | 71 +++++++
 rtl/sram_fb_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fb_arbiter_if.sv
// rtl/sram_fb_arbiter_if.sv - scan-out, pixel write/read, clear and SRAM pin bundle for the framebuffer arbiter
interface sram_fb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int X_W    = 10,
  parameter int Y_W    = 10
) ();

  // Video scan-out port
  logic              vid_active;
  logic [X_W-1:0]    draw_x;
  logic [Y_W-1:0]    draw_y;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;

  // Draw-logic pixel write port
  logic              wr_valid;
  logic              wr_ready;
  logic [X_W-1:0]    wr_x;
  logic [Y_W-1:0]    wr_y;
  logic [DATA_W-1:0] wr_color;

  // CPU single-pixel read port
  logic              rd_valid;
  logic              rd_ready;
  logic [X_W-1:0]    rd_x;
  logic [Y_W-1:0]    rd_y;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;

  // Clear-screen control
  logic              clear_req;
  logic              busy;

  // Off-chip asynchronous SRAM pins
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic [DATA_W-1:0] sram_dq_out;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_in;

  // Arbiter side
  modport slave (
    input  vid_active, draw_x, draw_y,
    output vid_data, vid_valid,
    input  wr_valid, wr_x, wr_y, wr_color,
    output wr_ready,
    input  rd_valid, rd_x, rd_y,
    output rd_ready, rd_done, rd_data,
    input  clear_req,
    output busy,
    output sram_addr, sram_we_n, sram_oe_n, sram_dq_out, sram_dq_oe,
    input  sram_dq_in
  );

  // Client / board side
  modport master (
    output vid_active, draw_x, draw_y,
    input  vid_data, vid_valid,
    output wr_valid, wr_x, wr_y, wr_color,
    input  wr_ready,
    output rd_valid, rd_x, rd_y,
    input  rd_ready, rd_done, rd_data,
    output clear_req,
    input  busy,
    input  sram_addr, sram_we_n, sram_oe_n, sram_dq_out, sram_dq_oe,
    output sram_dq_in
  );

endinterface

// File: rtl/sram_fb_arbiter.sv
// rtl/sram_fb_arbiter.sv - framebuffer SRAM arbiter: video reads, CPU reads, queued writes, clear sweep
module sram_fb_arbiter #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 20,
  parameter int                X_W         = 10,
  parameter int                Y_W         = 10,
  parameter int                X_SHIFT     = 1,
  parameter int                Y_BITS      = 9,
  parameter int                FIFO_DEPTH  = 8,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = DATA_W'(16'hFFFF)
) (
  input logic              clk,
  input logic              reset,
  sram_fb_arbiter_if.slave bus
);

  // Number of address bits the framebuffer actually spans; the clear sweep walks all of them.
  localparam int AW_USED = X_W - X_SHIFT + Y_BITS;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  localparam logic [AW_USED-1:0] CLR_LAST = '1;
  localparam logic [PTR_W:0]     DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0]  Y_MASK   = ADDR_W'((64'd1 << Y_BITS) - 64'd1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  // Pixel coordinate to word address: drop replicated low x bits, keep Y_BITS of y below them.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] xa;
    logic [ADDR_W-1:0] ya;
    xa = ADDR_W'(x >> X_SHIFT) << Y_BITS;
    ya = ADDR_W'(y) & Y_MASK;
    return xa | ya;
  endfunction

  // Clear FSM state
  state_t               state;
  logic [AW_USED-1:0]   clr_cnt;
  logic                 busy_q;

  // Write FIFO
  logic [ADDR_W-1:0]    fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0]    fifo_color [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic [PTR_W:0]       count_next;
  logic                 wr_ready_q;

  // CPU read channel
  logic                 rd_pend;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic                 rd_ready_q;
  logic                 rd_p1;
  logic                 rd_done_q;
  logic [DATA_W-1:0]    rd_data_q;

  // Video read pipeline
  logic                 vid_p1;
  logic                 vid_valid_q;
  logic [DATA_W-1:0]    vid_data_q;

  // Registered SRAM pins
  logic [ADDR_W-1:0]    sram_addr_q;
  logic                 sram_we_n_q;
  logic                 sram_oe_n_q;
  logic [DATA_W-1:0]    sram_dq_out_q;
  logic                 sram_dq_oe_q;

  // Per-cycle decisions
  logic                 clear_start;
  logic                 gnt_vid;
  logic                 gnt_clr;
  logic                 gnt_rd;
  logic                 gnt_wr;
  logic                 push;
  logic                 rd_accept;

  // Grant selection: video > clear sweep > CPU read > FIFO write; the clear start cycle grants nothing
  // below video so the FIFO flush never races a pop.
  always_comb begin
    clear_start = (state == ST_IDLE) && bus.clear_req;
    gnt_vid     = bus.vid_active;
    gnt_clr     = !bus.vid_active && (state == ST_CLEAR);
    gnt_rd      = !bus.vid_active && (state == ST_IDLE) && !clear_start && rd_pend;
    gnt_wr      = !bus.vid_active && (state == ST_IDLE) && !clear_start && !rd_pend && (count != '0);
    push        = bus.wr_valid && wr_ready_q;
    rd_accept   = bus.rd_valid && rd_ready_q;
    if (clear_start) begin
      count_next = (PTR_W + 1)'(push);
    end else begin
      count_next = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(gnt_wr);
    end
  end

  // Clear FSM: IDLE waits for clear_req, CLEAR writes one word per non-video cycle until the last address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (gnt_clr) begin
            if (clr_cnt == CLR_LAST) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end else begin
              clr_cnt <= clr_cnt + AW_USED'(1);
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; a flush jumps the read pointer to the write pointer so a same-cycle push survives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (clear_start) begin
        rd_ptr <= wr_ptr;
      end else if (gnt_wr) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count      <= count_next;
      wr_ready_q <= (count_next != DEPTH_C);
    end
  end

  // FIFO storage; entries hold the already-mapped address so the write grant needs no arithmetic.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= map_addr(bus.wr_x, bus.wr_y);
      fifo_color[wr_ptr] <= bus.wr_color;
    end
  end

  // CPU read channel: one request held until granted, result captured the cycle after the grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_pend    <= 1'b0;
      rd_addr_q  <= '0;
      rd_ready_q <= 1'b0;
      rd_p1      <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (rd_accept) begin
        rd_pend    <= 1'b1;
        rd_addr_q  <= map_addr(bus.rd_x, bus.rd_y);
        rd_ready_q <= 1'b0;
      end else if (gnt_rd) begin
        rd_pend <= 1'b0;
      end
      rd_p1     <= gnt_rd;
      rd_done_q <= rd_p1;
      if (rd_p1) begin
        rd_data_q  <= bus.sram_dq_in;
        rd_ready_q <= 1'b1;
      end else if (!rd_pend && !rd_accept && !gnt_rd) begin
        rd_ready_q <= 1'b1;
      end
    end
  end

  // Video pipeline: address out after the grant cycle, data captured one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vid_p1      <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
    end else begin
      vid_p1      <= gnt_vid;
      vid_valid_q <= vid_p1;
      if (vid_p1) begin
        vid_data_q <= bus.sram_dq_in;
      end
    end
  end

  // SRAM pins: strobes default inactive every cycle, so any write lasts exactly one cycle and
  // a non-write cycle always releases the data bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sram_addr_q   <= '0;
      sram_we_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
    end else begin
      sram_we_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      sram_dq_oe_q <= 1'b0;
      if (gnt_vid) begin
        sram_addr_q <= map_addr(bus.draw_x, bus.draw_y);
        sram_oe_n_q <= 1'b0;
      end else if (gnt_clr) begin
        sram_addr_q   <= ADDR_W'(clr_cnt);
        sram_dq_out_q <= CLEAR_COLOR;
        sram_dq_oe_q  <= 1'b1;
        sram_we_n_q   <= 1'b0;
      end else if (gnt_rd) begin
        sram_addr_q <= rd_addr_q;
        sram_oe_n_q <= 1'b0;
      end else if (gnt_wr) begin
        sram_addr_q   <= fifo_addr[rd_ptr];
        sram_dq_out_q <= fifo_color[rd_ptr];
        sram_dq_oe_q  <= 1'b1;
        sram_we_n_q   <= 1'b0;
      end
    end
  end

  assign bus.vid_data    = vid_data_q;
  assign bus.vid_valid   = vid_valid_q;
  assign bus.wr_ready    = wr_ready_q;
  assign bus.rd_ready    = rd_ready_q;
  assign bus.rd_done     = rd_done_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = busy_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_we_n   = sram_we_n_q;
  assign bus.sram_oe_n   = sram_oe_n_q;
  assign bus.sram_dq_out = sram_dq_out_q;
  assign bus.sram_dq_oe  = sram_dq_oe_q;

endmodule
